// File: rtl/avg_threshold_detect_pkg.sv
// Shared types and defaults for the averaged-sample threshold detector.
// State encoding, default widths and default thresholds live here.
package avg_threshold_detect_pkg;

  localparam int W_DEF        = 16;
  localparam int DEBOUNCE_DEF = 4;
  localparam int CNT_W_DEF    = 8;
  localparam int DBC_W        = 4;

  localparam logic [W_DEF-1:0] THR_HI_DEF = 16'd100;
  localparam logic [W_DEF-1:0] THR_LO_DEF = 16'd50;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_BELOW,
    ST_PEND_HI,
    ST_ABOVE,
    ST_PEND_LO
  } state_t;

endpackage

// File: rtl/avg_threshold_detect_if.sv
// Sample stream and threshold bundle feeding avg_threshold_detect.
// The master drives samples and thresholds; the detector is the slave.
interface avg_threshold_detect_if #(
  parameter int W = 16
) ();

  logic [W-1:0] avg_in;
  logic         avg_valid;
  logic [W-1:0] thr_hi;
  logic [W-1:0] thr_lo;

  modport master (output avg_in, output avg_valid, output thr_hi, output thr_lo);
  modport slave  (input  avg_in, input  avg_valid, input  thr_hi, input  thr_lo);

endinterface

// File: rtl/avg_threshold_detect_debounce.sv
// hyst_debounce_cnt: up-counter for a run of qualifying samples.
// tc is high when the next enabled increment completes the run.
module hyst_debounce_cnt #(
  parameter int DEBOUNCE = 4,
  parameter int DW       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cnt_en,
  input  logic cnt_clr,
  output logic tc
);

  localparam logic [DW-1:0] TC_VAL = DW'(DEBOUNCE - 1);

  logic [DW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/avg_threshold_detect.sv
// Hysteretic, debounced threshold detector on a running-average stream.
// Optional episode peak capture is enabled with macro AVG_PEAK_TRACK_EN.
//
// state      | meaning
// -----------+--------------------------------------------------
// ST_WAIT    | no sample seen since reset; first sample classifies
// ST_BELOW   | alert clear, no rise run in progress
// ST_PEND_HI | alert clear, counting samples >= thr_hi
// ST_ABOVE   | alert set, no fall run in progress
// ST_PEND_LO | alert set, counting samples < thr_lo
module avg_threshold_detect
  import avg_threshold_detect_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  avg_threshold_detect_if.slave  s_if,
  output logic                   alert,
  output logic                   rise_pulse,
  output logic                   fall_pulse,
  output logic [CNT_W-1:0]       event_cnt,
  output logic                   cfg_err,
  output logic [W-1:0]           peak_out,
  output logic                   peak_valid
);

  state_t             state_q, state_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic [CNT_W-1:0]   event_cnt_q;
  logic               cfg_err_q;
  logic               cnt_en, cnt_clr, cnt_tc;
  logic               act, is_hi, is_lo;

  // A bad threshold pair freezes everything, so samples only count when it is clear.
  assign act   = s_if.avg_valid && !cfg_err_q;
  assign is_hi = (s_if.avg_in >= s_if.thr_hi);
  assign is_lo = (s_if.avg_in <  s_if.thr_lo);

  hyst_debounce_cnt #(
    .DEBOUNCE (DEBOUNCE),
    .DW       (DBC_W)
  ) u_dbc (
    .clk     (clk),
    .rst     (rst),
    .cnt_en  (cnt_en),
    .cnt_clr (cnt_clr),
    .tc      (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (act) begin
      case (state_q)
        ST_WAIT: begin
          state_d = is_hi ? ST_ABOVE : ST_BELOW;
        end
        ST_BELOW, ST_PEND_HI: begin
          if (is_hi) begin
            if (cnt_tc) begin
              state_d = ST_ABOVE;
              cnt_clr = 1'b1;
              rise_d  = 1'b1;
            end else begin
              state_d = ST_PEND_HI;
              cnt_en  = 1'b1;
            end
          end else begin
            state_d = ST_BELOW;
            cnt_clr = 1'b1;
          end
        end
        ST_ABOVE, ST_PEND_LO: begin
          if (is_lo) begin
            if (cnt_tc) begin
              state_d = ST_BELOW;
              cnt_clr = 1'b1;
              fall_d  = 1'b1;
            end else begin
              state_d = ST_PEND_LO;
              cnt_en  = 1'b1;
            end
          end else begin
            state_d = ST_ABOVE;
            cnt_clr = 1'b1;
          end
        end
        default: begin
          state_d = ST_WAIT;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_WAIT;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      event_cnt_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      cfg_err_q <= (s_if.thr_lo > s_if.thr_hi);
      if (rise_d && (event_cnt_q != {CNT_W{1'b1}})) begin
        event_cnt_q <= event_cnt_q + 1'b1;
      end
    end
  end

  assign alert      = (state_q == ST_ABOVE) || (state_q == ST_PEND_LO);
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign event_cnt  = event_cnt_q;
  assign cfg_err    = cfg_err_q;

`ifdef AVG_PEAK_TRACK_EN
  logic [W-1:0] peak_q, peak_out_q, peak_max;
  logic         peak_valid_q;
  logic         episode_start;

  assign peak_max      = (s_if.avg_in > peak_q) ? s_if.avg_in : peak_q;
  // An episode opens on the first qualifying sample, including the initial classification.
  assign episode_start = is_hi && ((state_q == ST_BELOW) || (state_q == ST_WAIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q       <= '0;
      peak_out_q   <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      peak_valid_q <= 1'b0;
      if (act) begin
        if (episode_start) begin
          peak_q <= s_if.avg_in;
        end else if ((state_q == ST_PEND_HI) || (state_q == ST_ABOVE) ||
                     (state_q == ST_PEND_LO)) begin
          peak_q <= peak_max;
        end
        if (fall_d) begin
          peak_out_q   <= peak_max;
          peak_valid_q <= 1'b1;
        end
      end
    end
  end

  assign peak_out   = peak_out_q;
  assign peak_valid = peak_valid_q;
`else
  assign peak_out   = '0;
  assign peak_valid = 1'b0;
`endif

endmodule

// File: tb/tb_avg_threshold_detect.sv
// Directed bench for avg_threshold_detect: a default instance plus a
// CNT_W=2 instance sharing one sample stream, hand-computed expectations.
module tb_avg_threshold_detect;
  import avg_threshold_detect_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  avg_threshold_detect_if #(.W(16)) bus ();

  logic        alert, rise_pulse, fall_pulse, cfg_err, peak_valid;
  logic [7:0]  event_cnt;
  logic [15:0] peak_out;
  logic        s_alert, s_rise, s_fall, s_cfg_err, s_peak_valid;
  logic [1:0]  s_event_cnt;
  logic [15:0] s_peak_out;

  avg_threshold_detect #(.W(16), .DEBOUNCE(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_if       (bus.slave),
    .alert      (alert),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .event_cnt  (event_cnt),
    .cfg_err    (cfg_err),
    .peak_out   (peak_out),
    .peak_valid (peak_valid)
  );

  avg_threshold_detect #(.W(16), .DEBOUNCE(4), .CNT_W(2)) u_sat (
    .clk        (clk),
    .rst        (rst),
    .s_if       (bus.slave),
    .alert      (s_alert),
    .rise_pulse (s_rise),
    .fall_pulse (s_fall),
    .event_cnt  (s_event_cnt),
    .cfg_err    (s_cfg_err),
    .peak_out   (s_peak_out),
    .peak_valid (s_peak_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pk(input logic [15:0] v);
`ifdef AVG_PEAK_TRACK_EN
    return v;
`else
    return 16'd0;
`endif
  endfunction

  function automatic logic pv(input logic v);
`ifdef AVG_PEAK_TRACK_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input logic [15:0] v);
    @(negedge clk);
    bus.avg_valid = 1'b1;
    bus.avg_in    = v;
    @(posedge clk);
    #1;
    bus.avg_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_thr(input logic [15:0] hi, input logic [15:0] lo);
    @(negedge clk);
    bus.thr_hi = hi;
    bus.thr_lo = lo;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_out(input string tag, input logic a, input logic r, input logic f,
                         input logic [7:0] e, input logic [1:0] es);
    check({tag, ".alert"}, alert, a);
    check({tag, ".rise"}, rise_pulse, r);
    check({tag, ".fall"}, fall_pulse, f);
    check({tag, ".event"}, event_cnt, e);
    check({tag, ".sat_event"}, s_event_cnt, es);
    check({tag, ".sat_alert"}, s_alert, a);
  endtask

  task automatic exp_peak(input string tag, input logic [15:0] p, input logic v);
    check({tag, ".peak_out"}, peak_out, pk(p));
    check({tag, ".peak_valid"}, peak_valid, pv(v));
  endtask

  initial begin
    bus.avg_in    = '0;
    bus.avg_valid = 1'b0;
    bus.thr_hi    = THR_HI_DEF;
    bus.thr_lo    = THR_LO_DEF;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_out("reset", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    check("reset.cfg_err", cfg_err, 1'b0);
    check("reset.peak_out", peak_out, 16'd0);
    check("reset.peak_valid", peak_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // quiet stream below threshold
    drive(16'd10);
    exp_out("low1", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    drive(16'd10);
    exp_out("low2", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);

    // rise run of four
    drive(16'd10);
    for (int i = 0; i < 3; i++) begin
      drive(16'd120);
      exp_out("rise_run", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    end
    drive(16'd120);
    exp_out("rise1", 1'b1, 1'b1, 1'b0, 8'd1, 2'd1);
    idle(1);
    exp_out("rise1_after", 1'b1, 1'b0, 1'b0, 8'd1, 2'd1);
    drive(16'd130);
    drive(16'd200);
    drive(16'd150);
    exp_out("above_hold", 1'b1, 1'b0, 1'b0, 8'd1, 2'd1);

    // fall run broken by 60, then four consecutive 40s
    drive(16'd40);
    drive(16'd40);
    drive(16'd60);
    exp_out("fall_broken", 1'b1, 1'b0, 1'b0, 8'd1, 2'd1);
    for (int i = 0; i < 3; i++) begin
      drive(16'd40);
      exp_out("fall_run", 1'b1, 1'b0, 1'b0, 8'd1, 2'd1);
    end
    drive(16'd40);
    exp_out("fall1", 1'b0, 1'b0, 1'b1, 8'd1, 2'd1);
    exp_peak("fall1", 16'd200, 1'b1);
    idle(1);
    exp_out("fall1_after", 1'b0, 1'b0, 1'b0, 8'd1, 2'd1);
    exp_peak("fall1_after", 16'd200, 1'b0);

    // invalid cycles inside a run do not reset it
    drive(16'd150);
    idle(1);
    drive(16'd150);
    idle(2);
    drive(16'd150);
    exp_out("gap_run", 1'b0, 1'b0, 1'b0, 8'd1, 2'd1);
    drive(16'd150);
    exp_out("rise2", 1'b1, 1'b1, 1'b0, 8'd2, 2'd2);
    for (int i = 0; i < 3; i++) drive(16'd10);
    exp_out("fall2_run", 1'b1, 1'b0, 1'b0, 8'd2, 2'd2);
    drive(16'd10);
    exp_out("fall2", 1'b0, 1'b0, 1'b1, 8'd2, 2'd2);
    exp_peak("fall2", 16'd150, 1'b1);

    // config error freezes a partial run, then resumes it
    drive(16'd200);
    drive(16'd200);
    set_thr(16'd100, 16'd120);
    check("cfg_err.set", cfg_err, 1'b1);
    for (int i = 0; i < 5; i++) drive(16'd250);
    exp_out("cfg_frozen", 1'b0, 1'b0, 1'b0, 8'd2, 2'd2);
    check("cfg_err.hold", cfg_err, 1'b1);
    set_thr(16'd100, 16'd50);
    check("cfg_err.clear", cfg_err, 1'b0);
    drive(16'd210);
    exp_out("resume3", 1'b0, 1'b0, 1'b0, 8'd2, 2'd2);
    drive(16'd210);
    exp_out("rise3", 1'b1, 1'b1, 1'b0, 8'd3, 2'd3);
    for (int i = 0; i < 3; i++) drive(16'd10);
    drive(16'd10);
    exp_out("fall3", 1'b0, 1'b0, 1'b1, 8'd3, 2'd3);
    exp_peak("fall3", 16'd210, 1'b1);

    // full-width unsigned compares and threshold equality
    set_thr(16'h7000, 16'h1000);
    drive(16'h6FFF);
    drive(16'h6FFF);
    exp_out("wide_below", 1'b0, 1'b0, 1'b0, 8'd3, 2'd3);
    drive(16'h7000);
    drive(16'hF000);
    drive(16'hF000);
    exp_out("wide_run", 1'b0, 1'b0, 1'b0, 8'd3, 2'd3);
    drive(16'h7000);
    exp_out("rise4", 1'b1, 1'b1, 1'b0, 8'd4, 2'd3);
    drive(16'h0FFF);
    drive(16'h0FFF);
    drive(16'h1000);
    exp_out("wide_lo_eq", 1'b1, 1'b0, 1'b0, 8'd4, 2'd3);
    for (int i = 0; i < 3; i++) drive(16'h0FFF);
    exp_out("wide_fall_run", 1'b1, 1'b0, 1'b0, 8'd4, 2'd3);
    drive(16'h0FFF);
    exp_out("fall4", 1'b0, 1'b0, 1'b1, 8'd4, 2'd3);
    exp_peak("fall4", 16'hF000, 1'b1);

    // fifth episode, then reset mid-ABOVE
    set_thr(16'd100, 16'd50);
    for (int i = 0; i < 3; i++) drive(16'd120);
    drive(16'd120);
    exp_out("rise5", 1'b1, 1'b1, 1'b0, 8'd5, 2'd3);
    drive(16'd130);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_out("mid_reset", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    check("mid_reset.peak_valid", peak_valid, 1'b0);
    check("mid_reset.peak_out", peak_out, 16'd0);
    check("mid_reset.sat_fall", s_fall, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // first sample after reset classifies straight to ABOVE, silently
    drive(16'd150);
    exp_out("wait_above", 1'b1, 1'b0, 1'b0, 8'd0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avg_threshold_detect.md
AVG_THRESHOLD_DETECT -- requirements
Module: avg_threshold_detect

Interface
REQ-001 Parameter W, default 16: width of the average sample and the thresholds.
REQ-002 Parameter DEBOUNCE, default 4: consecutive qualifying samples needed to change alert state; legal range 1..15.
REQ-003 Parameter CNT_W, default 8: width of the event counter.
REQ-004 clk  input  1: single clock; all logic on its rising edge.
REQ-005 rst  input  1: reset, synchronous and active-high.
REQ-006 avg_in  input  W: running-average sample from the upstream averaging stage.
REQ-007 avg_valid  input  1: avg_in is qualified this cycle.
REQ-008 thr_hi  input  W: rise threshold, unsigned.
REQ-009 thr_lo  input  W: fall threshold, unsigned.
REQ-010 alert  output  1: level; high while the stream is in the alert condition.
REQ-011 rise_pulse  output  1: one-cycle pulse when alert sets.
REQ-012 fall_pulse  output  1: one-cycle pulse when alert clears.
REQ-013 event_cnt  output  CNT_W: count of rise events, saturating.
REQ-014 cfg_err  output  1: level; high while thr_lo > thr_hi.
REQ-015 peak_out  output  W: maximum avg_in seen during the last alert episode.
REQ-016 peak_valid  output  1: one-cycle pulse qualifying peak_out.

Function
REQ-017 FSM states: WAIT, BELOW, PEND_HI, ABOVE, PEND_LO; state advances only in cycles with avg_valid=1.
REQ-018 WAIT: on the first valid sample, go to ABOVE if avg_in >= thr_hi, else BELOW; this first classification sets alert without rise_pulse and without incrementing event_cnt.
REQ-019 BELOW: avg_in >= thr_hi -> PEND_HI with debounce count 1, or straight to ABOVE when DEBOUNCE=1.
REQ-020 PEND_HI: avg_in >= thr_hi increments the count; at count=DEBOUNCE -> ABOVE; any sample < thr_hi -> BELOW with count cleared.
REQ-021 ABOVE: avg_in < thr_lo -> PEND_LO (or BELOW when DEBOUNCE=1); PEND_LO mirrors PEND_HI using < thr_lo, returning to ABOVE on any sample >= thr_lo.
REQ-022 alert = 1 in ABOVE and PEND_LO, else 0; registered, so it changes the cycle after the deciding valid sample (latency 1).
REQ-023 rise_pulse asserts on the BELOW/PEND_HI -> ABOVE transition, and fall_pulse on the PEND_LO/ABOVE -> BELOW transition, each for exactly one cycle and aligned with the alert edge; the two are never high together.
REQ-024 event_cnt increments on each rise_pulse and holds at 2^CNT_W-1.
REQ-025 cfg_err is registered as (thr_lo > thr_hi); while it is high the FSM, count and peak hold, and valid samples are ignored.
REQ-026 Comparisons are unsigned and full width W, with no truncation.
REQ-027 Invalid cycles (avg_valid=0) do not break a debounce run.

Reset
REQ-028 Reset drives the FSM to WAIT and the debounce count, alert, rise_pulse, fall_pulse, event_cnt, cfg_err, peak_out and peak_valid to 0.
REQ-029 Reset asserted mid-episode aborts it, with no fall_pulse and no peak_valid.

Configuration
REQ-030 With macro AVG_PEAK_TRACK_EN defined: the peak register loads avg_in on the first sample that enters PEND_HI and updates with max(peak, avg_in) on every valid sample through PEND_HI, ABOVE and PEND_LO.
REQ-031 With AVG_PEAK_TRACK_EN defined: on fall_pulse, peak_out presents the episode maximum and peak_valid pulses in the same cycle; peak_out holds until the next episode completes.
REQ-032 With AVG_PEAK_TRACK_EN not defined: peak_out and peak_valid are tied to 0 and no peak register exists.

Structure
REQ-033 A shared package holds the FSM state enum and the default threshold and width constants.
REQ-034 The debounce counter is a sub-module, hyst_debounce_cnt, with ports for count enable, clear, and terminal-count flag.

Verification
REQ-035 Reset, then valid samples 10,10 with thr_hi=100, thr_lo=50 -> alert=0, event_cnt=0, no pulses.
REQ-036 Samples 10, 120,120,120,120 (DEBOUNCE=4) -> rise_pulse one cycle after the 4th 120; alert=1; event_cnt=1.
REQ-037 In ABOVE, samples 40,40,60,40,40,40,40 -> no fall on the first run (broken by 60); fall_pulse after the 4th consecutive 40.
REQ-038 With AVG_PEAK_TRACK_EN defined, an episode with samples 120,130,200,150 then the fall run -> peak_out=200 and peak_valid pulses together with fall_pulse.
REQ-039 thr_lo=120, thr_hi=100 -> cfg_err=1 next cycle and the state frozen; restoring the thresholds resumes from the held state.
REQ-040 With CNT_W=2, five complete episodes -> event_cnt saturates at 3; rst mid-ABOVE -> all outputs 0 the next cycle with no fall_pulse.
